// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
//   arb_state_e  : arbiter ownership state (IDLE / OWN0 / OWN1)
//   TIMEOUT_DATA : read data returned to a master whose access was ended by the watchdog
//   GRANT_*      : one-hot grant encodings {m1,m0}
//   arbitrate()  : round-robin pick between the two cyc requests
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int unsigned WB_WIDTH     = 32;
    localparam logic [WB_WIDTH-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // Single requester wins outright; on a tie the master that did not own last wins.
    function automatic arb_state_e arbitrate(input logic cyc0, input logic cyc1,
                                             input logic last_m1);
        arb_state_e pick;
        pick = IDLE;
        if (cyc0 && cyc1) begin
            pick = last_m1 ? OWN0 : OWN1;
        end else if (cyc0) begin
            pick = OWN0;
        end else if (cyc1) begin
            pick = OWN1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_shared_bus_arbiter_if.sv
// Classic Wishbone bus bundle used on every arbiter port.
//   cyc/stb/we/addr/wdata : request, driven by the bus master
//   rdata/ack             : response, driven by the bus slave
// Modports: master (drives the request), slave (drives the response).
interface wb_shared_bus_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ack;

    modport master (output cyc, output stb, output we, output addr, output wdata,
                    input  rdata, input ack);

    modport slave  (input  cyc, input  stb, input  we, input  addr, input  wdata,
                    output rdata, output ack);
endinterface

// File: rtl/wb_arb_watchdog.sv
// Slave-stall watchdog: counts consecutive cycles with run_i high and flags the
// cycle in which the count reaches TIMEOUT_CYCLES-1. The counter restarts after
// an expiry, when run_i drops, or on clear_i.
//   clk, rst_n  : clock, asynchronous active-low reset
//   run_i       : owner strobing with no slave ack this cycle
//   clear_i     : ownership is changing this cycle
//   expire_c_o  : combinational, high in the cycle the limit is reached
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clear_i,
    output logic expire_c_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expire_c_o = run_i && (count_q == LIMIT);

    // Count stall cycles; any break in the stall restarts from zero.
    always_comb begin
        count_d = count_q;
        if (clear_i || !run_i || expire_c_o) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_shared_bus_arbiter.sv
// Two-master / one-slave classic Wishbone arbiter. Instruction fetch (m0) and
// load/store (m1) share one memory port; round-robin grant, held for the owner's
// whole cyc (burst lock). Grant takes effect one cycle after arbitration.
// Optional feature macro: WB_ARB_TIMEOUT_EN enables the slave-stall watchdog,
// which terminates a stalled access with TIMEOUT_DATA and sets sticky timeout_o.
//   clk, rst_n  : clock, asynchronous active-low reset
//   m0_bus      : master 0 (instruction) Wishbone port
//   m1_bus      : master 1 (data) Wishbone port
//   s_bus       : shared slave Wishbone port
//   grant_o     : one-hot current owner {m1,m0}, 2'b00 when idle
//   timeout_o   : sticky watchdog flag (0 when the watchdog is not built)
module wb_shared_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    wb_shared_bus_arbiter_if.slave          m0_bus,
    wb_shared_bus_arbiter_if.slave          m1_bus,
    wb_shared_bus_arbiter_if.master         s_bus,
    output logic [1:0]                      grant_o,
    output logic                            timeout_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_m1_q;
    logic       last_m1_d;
    logic       own_stb_c;
    logic       expire_c;

    // Next owner: arbitrate when idle or when the current owner has released cyc.
    always_comb begin
        state_d   = state_q;
        last_m1_d = last_m1_q;
        case (state_q)
            IDLE: state_d = arbitrate(m0_bus.cyc, m1_bus.cyc, last_m1_q);
            OWN0: if (!m0_bus.cyc) state_d = arbitrate(m0_bus.cyc, m1_bus.cyc, last_m1_q);
            OWN1: if (!m1_bus.cyc) state_d = arbitrate(m0_bus.cyc, m1_bus.cyc, last_m1_q);
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            if (state_d == OWN0) last_m1_d = 1'b0;
            if (state_d == OWN1) last_m1_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_m1_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_m1_q <= last_m1_d;
        end
    end

    assign own_stb_c = ((state_q == OWN0) && m0_bus.stb) || ((state_q == OWN1) && m1_bus.stb);

`ifdef WB_ARB_TIMEOUT_EN
    logic timeout_q;
    logic timeout_d;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (own_stb_c && !s_bus.ack),
        .clear_i    (state_d != state_q),
        .expire_c_o (expire_c)
    );

    // Sticky flag; only reset clears it.
    always_comb begin
        timeout_d = timeout_q | expire_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = own_stb_c ^ (^32'(TIMEOUT_CYCLES));
    assign expire_c           = 1'b0;
    assign timeout_o          = 1'b0;
`endif

    // Bus steering from the registered owner; the non-owner sees no data and no ack.
    always_comb begin
        s_bus.cyc    = 1'b0;
        s_bus.stb    = 1'b0;
        s_bus.we     = 1'b0;
        s_bus.addr   = ADDR_WIDTH'(0);
        s_bus.wdata  = DATA_WIDTH'(0);
        m0_bus.rdata = DATA_WIDTH'(0);
        m0_bus.ack   = 1'b0;
        m1_bus.rdata = DATA_WIDTH'(0);
        m1_bus.ack   = 1'b0;
        grant_o      = GRANT_NONE;
        case (state_q)
            OWN0: begin
                grant_o      = GRANT_M0;
                s_bus.cyc    = m0_bus.cyc;
                s_bus.stb    = m0_bus.stb;
                s_bus.we     = m0_bus.we;
                s_bus.addr   = m0_bus.addr;
                s_bus.wdata  = m0_bus.wdata;
                m0_bus.rdata = s_bus.rdata;
                m0_bus.ack   = s_bus.ack && m0_bus.stb;
                if (expire_c) begin
                    m0_bus.rdata = DATA_WIDTH'(TIMEOUT_DATA);
                    m0_bus.ack   = 1'b1;
                end
            end
            OWN1: begin
                grant_o      = GRANT_M1;
                s_bus.cyc    = m1_bus.cyc;
                s_bus.stb    = m1_bus.stb;
                s_bus.we     = m1_bus.we;
                s_bus.addr   = m1_bus.addr;
                s_bus.wdata  = m1_bus.wdata;
                m1_bus.rdata = s_bus.rdata;
                m1_bus.ack   = s_bus.ack && m1_bus.stb;
                if (expire_c) begin
                    m1_bus.rdata = DATA_WIDTH'(TIMEOUT_DATA);
                    m1_bus.ack   = 1'b1;
                end
            end
            default: ;
        endcase
        // A timed-out access is withdrawn from the slave in the expiry cycle.
        if (expire_c) begin
            s_bus.cyc = 1'b0;
            s_bus.stb = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_shared_bus_arbiter.sv
// Self-checking bench for wb_shared_bus_arbiter: directed scenarios plus a
// randomized run compared against a behavioural ownership model.
module tb_wb_shared_bus_arbiter;
    import wb_arb_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       timeout;

    always #5 clk = ~clk;

    wb_shared_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    wb_shared_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
    wb_shared_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

    wb_shared_bus_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_bus    (m0_if),
        .m1_bus    (m1_if),
        .s_bus     (s_if),
        .grant_o   (grant),
        .timeout_o (timeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0=none, 1=m0, 2=m1; last 0=m0, 1=m1.
    int m_owner;
    int m_last;
    int m_cnt;
    bit m_tflag;

    task automatic model_reset();
        m_owner = 0;
        m_last  = 1;
        m_cnt   = 0;
        m_tflag = 0;
    endtask

    task automatic model_tick();
        bit c0, c1, owner_cyc, owner_stb, stalled, expired;
        int nxt;
        c0 = m0_if.cyc;
        c1 = m1_if.cyc;
        owner_cyc = (m_owner == 1) ? c0 : (m_owner == 2) ? c1 : 1'b0;
        owner_stb = (m_owner == 1) ? m0_if.stb : (m_owner == 2) ? m1_if.stb : 1'b0;
        if (m_owner == 0 || !owner_cyc) begin
            if (c0 && c1)  nxt = (m_last == 1) ? 1 : 2;
            else if (c0)   nxt = 1;
            else if (c1)   nxt = 2;
            else           nxt = 0;
        end else begin
            nxt = m_owner;
        end
        stalled = (m_owner != 0) && owner_stb && !s_if.ack;
        expired = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        expired = stalled && (m_cnt == int'(TO) - 1);
        if (expired) m_tflag = 1;
`endif
        if (nxt != m_owner || !stalled || expired) m_cnt = 0;
        else m_cnt++;
        if (nxt != 0) m_last = nxt - 1;
        m_owner = nxt;
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = '0;
        m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0;
        s_if.ack = 0;  s_if.rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #3 rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 32'h40;
        s_if.ack = 1; s_if.rdata = 32'hA5A5_5A5A;
        @(posedge clk);
        #2;
        checks++;
        if (grant !== GRANT_M0) begin errors++; $display("FAIL rst_pre_grant got %b want %b", grant, GRANT_M0); end
        rst_n = 0;
        #1;
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b want 00", grant); end
        checks++;
        if ({s_if.cyc, s_if.stb, s_if.we} !== 3'b000) begin errors++; $display("FAIL rst_s_ctl got %b want 000", {s_if.cyc, s_if.stb, s_if.we}); end
        checks++;
        if (s_if.addr !== '0) begin errors++; $display("FAIL rst_s_addr got %h want 0", s_if.addr); end
        checks++;
        if ({m0_if.ack, m1_if.ack} !== 2'b00) begin errors++; $display("FAIL rst_acks got %b want 00", {m0_if.ack, m1_if.ack}); end
        checks++;
        if (m0_if.rdata !== '0) begin errors++; $display("FAIL rst_m0_data got %h want 0", m0_if.rdata); end
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", timeout); end
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.we = 0; m0_if.addr = 32'h100;
        #1;
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL single_latency got %b want 00", grant); end
        clk_step(); #1;
        checks++;
        if (grant !== GRANT_M0) begin errors++; $display("FAIL single_grant got %b want 01", grant); end
        checks++;
        if ({s_if.cyc, s_if.stb, s_if.we} !== 3'b110) begin errors++; $display("FAIL single_s_ctl got %b want 110", {s_if.cyc, s_if.stb, s_if.we}); end
        checks++;
        if (s_if.addr !== 32'h100) begin errors++; $display("FAIL single_addr got %h want 100", s_if.addr); end
        checks++;
        if (m0_if.ack !== 1'b0) begin errors++; $display("FAIL single_early_ack got %b want 0", m0_if.ack); end
        clk_step();
        clk_step();
        s_if.ack = 1; s_if.rdata = 32'h1234_5678;
        #1;
        checks++;
        if (m0_if.ack !== 1'b1) begin errors++; $display("FAIL single_ack got %b want 1", m0_if.ack); end
        checks++;
        if (m0_if.rdata !== 32'h1234_5678) begin errors++; $display("FAIL single_data got %h want 12345678", m0_if.rdata); end
        checks++;
        if (m1_if.ack !== 1'b0 || m1_if.rdata !== '0) begin errors++; $display("FAIL single_m1 got ack %b data %h want 0 0", m1_if.ack, m1_if.rdata); end
        clk_step();
        idle_inputs();
        clk_step(); #1;
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL single_release got %b want 00", grant); end
    endtask

    task automatic test_contention();
        logic [1:0] want;
        do_reset();
        m0_if.cyc = 1; m1_if.cyc = 1;
        for (int i = 0; i < 4; i++) begin
            clk_step(); #1;
            want = (i % 2 == 0) ? GRANT_M0 : GRANT_M1;
            checks++;
            if (grant !== want) begin errors++; $display("FAIL contention_%0d got %b want %b", i, grant, want); end
            if (want == GRANT_M0) begin m0_if.cyc = 0; m1_if.cyc = 1; end
            else begin m0_if.cyc = 1; m1_if.cyc = 0; end
        end
        idle_inputs();
        clk_step();
    endtask

    task automatic test_burst_lock();
        logic [31:0] wd;
        do_reset();
        m1_if.cyc = 1;
        clk_step();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 32'h999;
        for (int k = 0; k < 4; k++) begin
            wd = $urandom;
            m1_if.stb = 1; m1_if.we = 1; m1_if.addr = 32'h200 + 32'(4 * k); m1_if.wdata = wd;
            s_if.ack = 1;
            #1;
            checks++;
            if (grant !== GRANT_M1) begin errors++; $display("FAIL burst_grant_%0d got %b want 10", k, grant); end
            checks++;
            if (s_if.addr !== 32'h200 + 32'(4 * k) || s_if.wdata !== wd || s_if.we !== 1'b1) begin
                errors++; $display("FAIL burst_write_%0d got %h/%h we %b want %h/%h we 1", k, s_if.addr, s_if.wdata, s_if.we, 32'h200 + 32'(4 * k), wd);
            end
            checks++;
            if (m1_if.ack !== 1'b1 || m0_if.ack !== 1'b0) begin errors++; $display("FAIL burst_ack_%0d got m1 %b m0 %b want 1 0", k, m1_if.ack, m0_if.ack); end
            clk_step();
        end
        m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; s_if.ack = 0;
        #1;
        checks++;
        if (grant !== GRANT_M1 || s_if.cyc !== 1'b0) begin errors++; $display("FAIL burst_release got grant %b cyc %b want 10 0", grant, s_if.cyc); end
        clk_step(); #1;
        checks++;
        if (grant !== GRANT_M0 || s_if.addr !== 32'h999) begin errors++; $display("FAIL burst_handoff got grant %b addr %h want 01 999", grant, s_if.addr); end
        idle_inputs();
        clk_step();
    endtask

    task automatic test_stray_ack();
        do_reset();
        s_if.ack = 1; s_if.rdata = $urandom;
        #1;
        checks++;
        if ({m0_if.ack, m1_if.ack} !== 2'b00 || m0_if.rdata !== '0) begin errors++; $display("FAIL stray_idle got acks %b data %h want 00 0", {m0_if.ack, m1_if.ack}, m0_if.rdata); end
        clk_step(); #1;
        checks++;
        if (grant !== 2'b00) begin errors++; $display("FAIL stray_state got %b want 00", grant); end
        m0_if.cyc = 1; m0_if.stb = 0;
        clk_step(); #1;
        checks++;
        if (grant !== GRANT_M0 || m0_if.ack !== 1'b0) begin errors++; $display("FAIL stray_nostb got grant %b ack %b want 01 0", grant, m0_if.ack); end
        idle_inputs();
        clk_step();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 32'h300;
        clk_step();
        for (int k = 1; k <= int'(TO); k++) begin
            #1;
            checks++;
            if (k < int'(TO)) begin
                if (m0_if.ack !== 1'b0 || s_if.stb !== 1'b1) begin errors++; $display("FAIL to_stall_%0d got ack %b stb %b want 0 1", k, m0_if.ack, s_if.stb); end
            end else begin
                if (m0_if.ack !== 1'b1 || m0_if.rdata !== 32'hDEAD_BEEF || s_if.stb !== 1'b0 || s_if.cyc !== 1'b0) begin
                    errors++; $display("FAIL to_expire got ack %b data %h stb %b cyc %b want 1 deadbeef 0 0", m0_if.ack, m0_if.rdata, s_if.stb, s_if.cyc);
                end
            end
            checks++;
            if (timeout !== 1'b0) begin errors++; $display("FAIL to_early_flag_%0d got %b want 0", k, timeout); end
            clk_step();
        end
        #1;
        checks++;
        if (timeout !== 1'b1 || m0_if.ack !== 1'b0 || s_if.stb !== 1'b1) begin errors++; $display("FAIL to_after got flag %b ack %b stb %b want 1 0 1", timeout, m0_if.ack, s_if.stb); end
        idle_inputs();
        clk_step(); clk_step(); #1;
        checks++;
        if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", timeout); end
        do_reset(); #1;
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL to_reset got %b want 0", timeout); end
    endtask
`else
    task automatic test_stall();
        do_reset();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.addr = 32'h300;
        clk_step();
        for (int k = 0; k < 40; k++) begin
            #1;
            checks++;
            if (m0_if.ack !== 1'b0 || s_if.stb !== 1'b1 || timeout !== 1'b0) begin
                errors++; $display("FAIL stall_%0d got ack %b stb %b flag %b want 0 1 0", k, m0_if.ack, s_if.stb, timeout);
            end
            clk_step();
        end
        idle_inputs();
        clk_step();
    endtask
`endif

    task automatic test_random();
        int own;
        bit ecyc, estb, ewe, expired, e0a, e1a;
        logic [31:0] eaddr, ewd, e0d, e1d;
        logic [1:0] eg;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 25) m0_if.cyc = ~m0_if.cyc;
            if ($urandom_range(0, 99) < 25) m1_if.cyc = ~m1_if.cyc;
            m0_if.stb = m0_if.cyc & 1'($urandom); m0_if.we = 1'($urandom);
            m0_if.addr = $urandom; m0_if.wdata = $urandom;
            m1_if.stb = m1_if.cyc & 1'($urandom); m1_if.we = 1'($urandom);
            m1_if.addr = $urandom; m1_if.wdata = $urandom;
            s_if.ack = ($urandom_range(0, 99) < 30); s_if.rdata = $urandom;
            #1;
            own = m_owner;
            eg = (own == 1) ? GRANT_M0 : (own == 2) ? GRANT_M1 : 2'b00;
            ecyc = 0; estb = 0; ewe = 0; eaddr = '0; ewd = '0;
            if (own == 1) begin ecyc = m0_if.cyc; estb = m0_if.stb; ewe = m0_if.we; eaddr = m0_if.addr; ewd = m0_if.wdata; end
            if (own == 2) begin ecyc = m1_if.cyc; estb = m1_if.stb; ewe = m1_if.we; eaddr = m1_if.addr; ewd = m1_if.wdata; end
            expired = 0;
`ifdef WB_ARB_TIMEOUT_EN
            expired = (own != 0) && estb && !s_if.ack && (m_cnt == int'(TO) - 1);
`endif
            if (expired) begin ecyc = 0; estb = 0; end
            e0a = (own == 1) && (expired || (s_if.ack && m0_if.stb));
            e1a = (own == 2) && (expired || (s_if.ack && m1_if.stb));
            e0d = (own == 1) ? (expired ? 32'hDEAD_BEEF : s_if.rdata) : 32'h0;
            e1d = (own == 2) ? (expired ? 32'hDEAD_BEEF : s_if.rdata) : 32'h0;
            checks++;
            if (grant !== eg) begin errors++; $display("FAIL rnd_grant n=%0d got %b want %b", n, grant, eg); end
            checks++;
            if ({s_if.cyc, s_if.stb, s_if.we} !== {ecyc, estb, ewe}) begin errors++; $display("FAIL rnd_s_ctl n=%0d got %b want %b", n, {s_if.cyc, s_if.stb, s_if.we}, {ecyc, estb, ewe}); end
            checks++;
            if (s_if.addr !== eaddr || s_if.wdata !== ewd) begin errors++; $display("FAIL rnd_s_payload n=%0d got %h/%h want %h/%h", n, s_if.addr, s_if.wdata, eaddr, ewd); end
            checks++;
            if (m0_if.ack !== e0a || m0_if.rdata !== e0d) begin errors++; $display("FAIL rnd_m0 n=%0d got %b/%h want %b/%h", n, m0_if.ack, m0_if.rdata, e0a, e0d); end
            checks++;
            if (m1_if.ack !== e1a || m1_if.rdata !== e1d) begin errors++; $display("FAIL rnd_m1 n=%0d got %b/%h want %b/%h", n, m1_if.ack, m1_if.rdata, e1a, e1d); end
            checks++;
            if (timeout !== m_tflag) begin errors++; $display("FAIL rnd_timeout n=%0d got %b want %b", n, timeout, m_tflag); end
            clk_step();
        end
        idle_inputs();
        clk_step();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_burst_lock();
        test_stray_ack();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_stall();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_time_limit reached at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
